// File: rtl/test_pattern_gen_multi.sv
// test_pattern_gen_multi: registered self-test stimulus source for the capture path.
// Eight modes selected at runtime; a mode change restarts the chosen pattern cleanly
// with a sync pulse. Every output is a flop so downstream timing sees clean edges.
module test_pattern_gen_multi #(
    parameter int          DATA_WIDTH = 8,
    parameter int          DIV_WIDTH  = 16,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001,
    parameter int          BURST_LEN  = 16,
    parameter int          GAP_LEN    = 8,
    parameter int          FRAME_LEN  = 12,
    parameter logic [7:0]  SYNC_WORD  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [2:0]            pattern_sel,
    input  logic [DIV_WIDTH-1:0]  half_period,
    output logic [DATA_WIDTH-1:0] test_data,
    output logic                  data_valid,
    output logic                  sync_pulse
);

    typedef enum logic [2:0] {
        M_INC   = 3'b000,
        M_SQR   = 3'b001,
        M_LFSR  = 3'b010,
        M_ALT   = 3'b011,
        M_WALK  = 3'b100,
        M_GRAY  = 3'b101,
        M_BURST = 3'b110,
        M_FRAME = 3'b111
    } mode_t;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [31:0] SEED_EFF = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam int FW = $clog2(FRAME_LEN + 1);
    localparam int PW = DIV_WIDTH + 1;
    localparam logic [DATA_WIDTH-1:0] SYNC_W = DATA_WIDTH'(SYNC_WORD);

    // Alternating start word: bit i carries i[0], giving 0xAA at 8 bits.
    function automatic logic [DATA_WIDTH-1:0] alt_init();
        logic [DATA_WIDTH-1:0] v;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            v[i] = i[0];
        end
        return v;
    endfunction

    localparam logic [DATA_WIDTH-1:0] ALT_INIT = alt_init();

    // First word emitted when a mode is (re)started.
    function automatic logic [DATA_WIDTH-1:0] init_word(input logic [2:0] m);
        case (m)
            M_LFSR:  return SEED_EFF[DATA_WIDTH-1:0];
            M_ALT:   return ALT_INIT;
            M_WALK:  return DATA_WIDTH'(1);
            M_FRAME: return SYNC_W;
            default: return '0;
        endcase
    endfunction

    mode_t                 r_sel_q;
    logic [31:0]           r_lfsr;
    logic [DIV_WIDTH-1:0]  r_phase;
    logic [DATA_WIDTH-1:0] r_bin;
    logic [BW-1:0]         r_burst_cnt;
    logic [GW-1:0]         r_gap_cnt;
    logic                  r_in_gap;
    logic [FW-1:0]         r_frame_cnt;

    logic                  w_restart;
    logic [DATA_WIDTH-1:0] w_inc;
    logic [DATA_WIDTH-1:0] w_rot;
    logic [31:0]           w_lfsr_next;
    logic [DATA_WIDTH-1:0] w_bin_next;
    logic [DATA_WIDTH-1:0] w_gray_next;
    logic [DIV_WIDTH-1:0]  w_hp_eff;
    logic [PW-1:0]         w_phase_inc;
    logic                  w_phase_done;

    assign w_restart    = (pattern_sel != r_sel_q);
    assign w_inc        = test_data + DATA_WIDTH'(1);
    assign w_rot        = {test_data[DATA_WIDTH-2:0], test_data[DATA_WIDTH-1]};
    assign w_lfsr_next  = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
    assign w_bin_next   = r_bin + DATA_WIDTH'(1);
    assign w_gray_next  = w_bin_next ^ (w_bin_next >> 1);
    // A half period of 0 behaves like 1 so the square wave never stalls.
    assign w_hp_eff     = (half_period == '0) ? DIV_WIDTH'(1) : half_period;
    // One extra bit so the compare is safe even when half_period shrinks mid-phase.
    assign w_phase_inc  = {1'b0, r_phase} + PW'(1);
    assign w_phase_done = (w_phase_inc >= {1'b0, w_hp_eff});

    // Pattern engine: freeze when disabled, restart on mode change, else step the active mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_q     <= M_INC;
            r_lfsr      <= SEED_EFF;
            r_phase     <= '0;
            r_bin       <= '0;
            r_burst_cnt <= '0;
            r_gap_cnt   <= '0;
            r_in_gap    <= 1'b0;
            r_frame_cnt <= '0;
            test_data   <= '0;
            data_valid  <= 1'b0;
            sync_pulse  <= 1'b0;
        end else if (!enable) begin
            data_valid <= 1'b0;
            sync_pulse <= 1'b0;
        end else if (w_restart) begin
            r_sel_q     <= mode_t'(pattern_sel);
            r_lfsr      <= SEED_EFF;
            r_phase     <= '0;
            r_bin       <= '0;
            r_burst_cnt <= '0;
            r_gap_cnt   <= '0;
            r_in_gap    <= 1'b0;
            r_frame_cnt <= '0;
            test_data   <= init_word(pattern_sel);
            data_valid  <= 1'b1;
            sync_pulse  <= 1'b1;
        end else begin
            data_valid <= 1'b1;
            sync_pulse <= 1'b0;
            case (r_sel_q)
                M_INC: begin
                    test_data  <= w_inc;
                    sync_pulse <= (w_inc == '0);
                end
                M_SQR: begin
                    if (w_phase_done) begin
                        test_data <= ~test_data;
                        r_phase   <= '0;
                    end else begin
                        r_phase   <= w_phase_inc[DIV_WIDTH-1:0];
                    end
                end
                M_LFSR: begin
                    r_lfsr    <= w_lfsr_next;
                    test_data <= w_lfsr_next[DATA_WIDTH-1:0];
                end
                M_ALT: begin
                    test_data <= ~test_data;
                end
                M_WALK: begin
                    test_data  <= w_rot;
                    sync_pulse <= (w_rot == DATA_WIDTH'(1));
                end
                M_GRAY: begin
                    r_bin      <= w_bin_next;
                    test_data  <= w_gray_next;
                    sync_pulse <= (w_bin_next == '0);
                end
                M_BURST: begin
                    if (!r_in_gap) begin
                        if (r_burst_cnt == BW'(BURST_LEN - 1)) begin
                            r_in_gap   <= 1'b1;
                            r_gap_cnt  <= '0;
                            test_data  <= '0;
                            data_valid <= 1'b0;
                        end else begin
                            r_burst_cnt <= r_burst_cnt + BW'(1);
                            test_data   <= w_inc;
                        end
                    end else begin
                        if (r_gap_cnt == GW'(GAP_LEN - 1)) begin
                            r_in_gap    <= 1'b0;
                            r_burst_cnt <= '0;
                            test_data   <= '0;
                            sync_pulse  <= 1'b1;
                        end else begin
                            r_gap_cnt  <= r_gap_cnt + GW'(1);
                            test_data  <= '0;
                            data_valid <= 1'b0;
                        end
                    end
                end
                M_FRAME: begin
                    // Count 0 is the sync word slot; payload word k sits at count k+1.
                    if (r_frame_cnt == FW'(FRAME_LEN)) begin
                        r_frame_cnt <= '0;
                        test_data   <= SYNC_W;
                        sync_pulse  <= 1'b1;
                    end else begin
                        r_frame_cnt <= r_frame_cnt + FW'(1);
                        test_data   <= DATA_WIDTH'(r_frame_cnt);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_pattern_gen_multi.sv
// tb_test_pattern_gen_multi: scoreboard bench for test_pattern_gen_multi at 8 bits,
// short burst/gap/frame lengths so every mode wraps within a short run.
module tb_test_pattern_gen_multi;

    localparam int          W    = 8;
    localparam int          DW   = 16;
    localparam logic [31:0] SEED = 32'hACE1_0001;
    localparam int          BL   = 4;
    localparam int          GL   = 2;
    localparam int          FL   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [2:0]    sel;
    logic [DW-1:0] hp;
    logic [W-1:0]  test_data;
    logic          data_valid;
    logic          sync_pulse;

    test_pattern_gen_multi #(
        .DATA_WIDTH(W), .DIV_WIDTH(DW), .LFSR_SEED(SEED),
        .BURST_LEN(BL), .GAP_LEN(GL), .FRAME_LEN(FL), .SYNC_WORD(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pattern_sel(sel),
        .half_period(hp), .test_data(test_data), .data_valid(data_valid),
        .sync_pulse(sync_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         v;
        logic         s;
    } exp_t;

    typedef struct {
        logic          en;
        logic [2:0]    sel;
        logic [DW-1:0] hp;
    } stim_t;

    exp_t  exp_q[$];
    stim_t stim_q[$];
    int    checks = 0;
    int    errors = 0;

    // reference model state
    logic [2:0]  m_sel;
    logic [31:0] m_lfsr;
    logic [W-1:0] m_td;
    logic [W-1:0] m_bin;
    logic [16:0] m_phase;
    int          m_pos;

    task automatic model_reset();
        m_sel   = 3'd0;
        m_lfsr  = SEED;
        m_td    = '0;
        m_bin   = '0;
        m_phase = '0;
        m_pos   = 0;
        exp_q.delete();
    endtask

    task automatic add(input logic en, input logic [2:0] s, input logic [DW-1:0] h, input int n);
        stim_t st;
        st.en = en; st.sel = s; st.hp = h;
        for (int i = 0; i < n; i++) stim_q.push_back(st);
    endtask

    // Predict the word the DUT registers at the next edge, push it, then advance the clock.
    task automatic tick();
        exp_t e;
        int   k;
        logic [16:0] hpe;
        e.v = 1'b1;
        e.s = 1'b0;
        if (!enable) begin
            e.v = 1'b0;
        end else if (sel != m_sel) begin
            m_sel = sel; m_pos = 0; m_phase = '0; m_bin = '0; m_lfsr = SEED;
            case (sel)
                3'd2:    m_td = m_lfsr[7:0];
                3'd3:    m_td = 8'hAA;
                3'd4:    m_td = 8'h01;
                3'd7:    m_td = 8'hA5;
                default: m_td = 8'h00;
            endcase
            e.s = 1'b1;
        end else begin
            m_pos++;
            case (m_sel)
                3'd0: begin m_td = m_td + 8'd1; e.s = (m_td == 8'd0); end
                3'd1: begin
                    hpe = (hp == '0) ? 17'd1 : {1'b0, hp};
                    m_phase = m_phase + 17'd1;
                    if (m_phase >= hpe) begin m_td = ~m_td; m_phase = '0; end
                end
                3'd2: begin
                    m_lfsr = {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0]};
                    m_td = m_lfsr[7:0];
                end
                3'd3: m_td = ~m_td;
                3'd4: begin m_td = {m_td[6:0], m_td[7]}; e.s = (m_td == 8'd1); end
                3'd5: begin
                    m_bin = m_bin + 8'd1;
                    m_td = m_bin ^ (m_bin >> 1);
                    e.s = (m_bin == 8'd0);
                end
                3'd6: begin
                    k = m_pos % (BL + GL);
                    if (k < BL) begin m_td = 8'(k); e.s = (k == 0); end
                    else begin m_td = 8'd0; e.v = 1'b0; end
                end
                default: begin
                    k = m_pos % (FL + 1);
                    if (k == 0) begin m_td = 8'hA5; e.s = 1'b1; end
                    else m_td = 8'(k - 1);
                end
            endcase
        end
        e.d = m_td;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; sel = 3'd0; hp = 16'd3;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (test_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", test_data); end
        checks++;
        if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", data_valid); end
        checks++;
        if (sync_pulse !== 1'b0) begin errors++; $display("FAIL reset_sync got %b want 0", sync_pulse); end
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_increment();
        exp_t e;
        int   nsync = 0;
        logic [W-1:0] first = '0;
        add(1'b1, 3'd0, 16'd3, 260);
        for (int i = 0; i < stim_q.size(); i++) begin
            enable = stim_q[i].en; sel = stim_q[i].sel; hp = stim_q[i].hp;
            tick();
            if (i == 0) first = test_data;
            if (sync_pulse === 1'b1) nsync++;
            e = exp_q.pop_front();
            checks++;
            if ({test_data, data_valid, sync_pulse} !== {e.d, e.v, e.s}) begin
                errors++;
                $display("FAIL increment[%0d] got d=%h v=%b s=%b want d=%h v=%b s=%b",
                         i, test_data, data_valid, sync_pulse, e.d, e.v, e.s);
            end
        end
        stim_q.delete();
        checks++;
        if (first !== 8'h01) begin errors++; $display("FAIL increment_first got %h want 01", first); end
        checks++;
        if (nsync !== 1) begin errors++; $display("FAIL increment_sync_count got %0d want 1", nsync); end
    endtask

    task automatic test_square();
        exp_t e;
        add(1'b1, 3'd1, 16'd3, 14);
        add(1'b1, 3'd1, 16'd0, 6);
        add(1'b1, 3'd1, 16'd2, 8);
        for (int i = 0; i < stim_q.size(); i++) begin
            enable = stim_q[i].en; sel = stim_q[i].sel; hp = stim_q[i].hp;
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({test_data, data_valid, sync_pulse} !== {e.d, e.v, e.s}) begin
                errors++;
                $display("FAIL square[%0d] got d=%h v=%b s=%b want d=%h v=%b s=%b",
                         i, test_data, data_valid, sync_pulse, e.d, e.v, e.s);
            end
        end
        stim_q.delete();
    endtask

    task automatic test_lfsr();
        exp_t e;
        logic [W-1:0] first = '0;
        add(1'b1, 3'd2, 16'd0, 1000);
        for (int i = 0; i < stim_q.size(); i++) begin
            enable = stim_q[i].en; sel = stim_q[i].sel; hp = stim_q[i].hp;
            tick();
            if (i == 0) first = test_data;
            e = exp_q.pop_front();
            checks++;
            if ({test_data, data_valid, sync_pulse} !== {e.d, e.v, e.s}) begin
                errors++;
                $display("FAIL lfsr[%0d] got d=%h v=%b s=%b want d=%h v=%b s=%b",
                         i, test_data, data_valid, sync_pulse, e.d, e.v, e.s);
            end
        end
        stim_q.delete();
        checks++;
        if (first !== 8'h01) begin errors++; $display("FAIL lfsr_first got %h want 01", first); end
    endtask

    task automatic test_alt_walk();
        exp_t e;
        int   nsync = 0;
        add(1'b1, 3'd3, 16'd0, 6);
        add(1'b1, 3'd4, 16'd0, 20);
        for (int i = 0; i < stim_q.size(); i++) begin
            enable = stim_q[i].en; sel = stim_q[i].sel; hp = stim_q[i].hp;
            tick();
            if (i >= 6 && sync_pulse === 1'b1) nsync++;
            e = exp_q.pop_front();
            checks++;
            if ({test_data, data_valid, sync_pulse} !== {e.d, e.v, e.s}) begin
                errors++;
                $display("FAIL alt_walk[%0d] got d=%h v=%b s=%b want d=%h v=%b s=%b",
                         i, test_data, data_valid, sync_pulse, e.d, e.v, e.s);
            end
        end
        stim_q.delete();
        checks++;
        if (nsync !== 3) begin errors++; $display("FAIL walk_sync_count got %0d want 3", nsync); end
    endtask

    task automatic test_gray();
        exp_t e;
        add(1'b1, 3'd5, 16'd0, 300);
        for (int i = 0; i < stim_q.size(); i++) begin
            enable = stim_q[i].en; sel = stim_q[i].sel; hp = stim_q[i].hp;
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({test_data, data_valid, sync_pulse} !== {e.d, e.v, e.s}) begin
                errors++;
                $display("FAIL gray[%0d] got d=%h v=%b s=%b want d=%h v=%b s=%b",
                         i, test_data, data_valid, sync_pulse, e.d, e.v, e.s);
            end
        end
        stim_q.delete();
    endtask

    // Burst with a mid-burst pause, then a mode change made while disabled, then framing.
    task automatic test_burst_frame();
        exp_t e;
        add(1'b1, 3'd6, 16'd0, 15);
        add(1'b0, 3'd6, 16'd0, 5);
        add(1'b1, 3'd6, 16'd0, 10);
        add(1'b0, 3'd7, 16'd0, 2);
        add(1'b1, 3'd7, 16'd0, 12);
        for (int i = 0; i < stim_q.size(); i++) begin
            enable = stim_q[i].en; sel = stim_q[i].sel; hp = stim_q[i].hp;
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({test_data, data_valid, sync_pulse} !== {e.d, e.v, e.s}) begin
                errors++;
                $display("FAIL burst_frame[%0d] got d=%h v=%b s=%b want d=%h v=%b s=%b",
                         i, test_data, data_valid, sync_pulse, e.d, e.v, e.s);
            end
        end
        stim_q.delete();
    endtask

    task automatic test_async_reset();
        exp_t e;
        logic [W-1:0] first = '0;
        add(1'b1, 3'd0, 16'd0, 5);
        for (int i = 0; i < stim_q.size(); i++) begin
            enable = stim_q[i].en; sel = stim_q[i].sel; hp = stim_q[i].hp;
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({test_data, data_valid, sync_pulse} !== {e.d, e.v, e.s}) begin
                errors++;
                $display("FAIL pre_reset[%0d] got d=%h v=%b s=%b want d=%h v=%b s=%b",
                         i, test_data, data_valid, sync_pulse, e.d, e.v, e.s);
            end
        end
        stim_q.delete();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({test_data, data_valid, sync_pulse} !== 10'b0) begin
            errors++;
            $display("FAIL async_reset got d=%h v=%b s=%b want d=00 v=0 s=0", test_data, data_valid, sync_pulse);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({test_data, data_valid, sync_pulse} !== 10'b0) begin
            errors++;
            $display("FAIL reset_hold got d=%h v=%b s=%b want d=00 v=0 s=0", test_data, data_valid, sync_pulse);
        end
        model_reset();
        rst = 1'b0;
        add(1'b1, 3'd0, 16'd0, 5);
        for (int i = 0; i < stim_q.size(); i++) begin
            enable = stim_q[i].en; sel = stim_q[i].sel; hp = stim_q[i].hp;
            tick();
            if (i == 0) first = test_data;
            e = exp_q.pop_front();
            checks++;
            if ({test_data, data_valid, sync_pulse} !== {e.d, e.v, e.s}) begin
                errors++;
                $display("FAIL post_reset[%0d] got d=%h v=%b s=%b want d=%h v=%b s=%b",
                         i, test_data, data_valid, sync_pulse, e.d, e.v, e.s);
            end
        end
        stim_q.delete();
        checks++;
        if (first !== 8'h01) begin errors++; $display("FAIL post_reset_first got %h want 01", first); end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_square();
        test_lfsr();
        test_alt_walk();
        test_gray();
        test_burst_frame();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
